// File: rtl/elastic_demux.sv
// elastic_demux: elastic 1-to-N valid/ready demultiplexer with a 2-entry {sel,data} FIFO.
//   clk, rst_n          clock, synchronous active-low reset
//   sel, in_data        destination index and word, captured with an accepted beat
//   in_valid, in_ready  input handshake; in_ready comes from registered FIFO state
//   out_data            NUM_OUTPUTS packed slices; only the head's slice is non-zero
//   out_valid, out_ready per-output handshake, at most one valid bit high
//   sel_err             sticky flag: a beat with an out-of-range sel was dropped
module elastic_demux #(
    parameter int NUM_OUTPUTS = 2,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [$clog2(NUM_OUTPUTS)-1:0]    sel,
    input  logic [DATA_WIDTH-1:0]             in_data,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic [NUM_OUTPUTS*DATA_WIDTH-1:0] out_data,
    output logic [NUM_OUTPUTS-1:0]            out_valid,
    input  logic [NUM_OUTPUTS-1:0]            out_ready,
    output logic                              sel_err
);
    localparam int SW = $clog2(NUM_OUTPUTS);
    logic [1:0]            count_q, count_d;
    logic [SW-1:0]         sel_q  [2];
    logic [SW-1:0]         sel_d  [2];
    logic [DATA_WIDTH-1:0] data_q [2];
    logic [DATA_WIDTH-1:0] data_d [2];
    logic                  sel_err_q, sel_err_d;
    logic                  head_ok, head_bad, push, pop, wr;
    // Entry 0 is always the head; a pop shifts entry 1 down.
    always_comb begin
        head_ok   = rst_n && count_q != 2'd0 && int'(sel_q[0]) < NUM_OUTPUTS;
        head_bad  = rst_n && count_q != 2'd0 && !(int'(sel_q[0]) < NUM_OUTPUTS);
        in_ready  = rst_n && count_q != 2'd2;
        out_valid = '0;
        out_data  = '0;
        if (head_ok) begin
            out_valid[sel_q[0]] = 1'b1;
            out_data[int'(sel_q[0])*DATA_WIDTH +: DATA_WIDTH] = data_q[0];
        end
        sel_err   = sel_err_q || head_bad;
    end
    // An out-of-range head is dropped at the first edge it sits at the head.
    always_comb begin
        push      = in_valid && in_ready;
        pop       = head_bad || |(out_valid & out_ready);
        count_d   = count_q + {1'b0, push} - {1'b0, pop};
        wr        = count_q == 2'd1 && !pop;
        sel_d     = sel_q;
        data_d    = data_q;
        if (pop) begin
            sel_d[0]  = sel_q[1];
            data_d[0] = data_q[1];
        end
        if (push) begin
            sel_d[wr]  = sel;
            data_d[wr] = in_data;
        end
        sel_err_d = sel_err_q || head_bad;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q   <= 2'd0;
            sel_err_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            sel_err_q <= sel_err_d;
        end
    end
    // Payload needs no reset: it is masked whenever count is zero.
    always_ff @(posedge clk) begin
        sel_q  <= sel_d;
        data_q <= data_d;
    end
endmodule
